// File: rtl/cache_set_nway.sv
// N-way set-associative cache set with tag compare, victim selection and replacement bookkeeping.
// Define CACHE_SET_LRU_EN for true-LRU replacement; otherwise a round-robin pointer is used.
module cache_set_nway #(
    parameter int unsigned WAYS       = 2,
    parameter int unsigned TAG_W      = 5,
    parameter int unsigned WORD_W     = 16,
    parameter int unsigned LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          cmp,
    input  logic                          write,
    input  logic [$clog2(LINE_WORDS)-1:0] word,
    input  logic [TAG_W-1:0]              tag,
    input  logic [WORD_W-1:0]             data_in,
    input  logic                          valid_in,
    output logic                          hit,
    output logic                          dirty,
    output logic [TAG_W-1:0]              tag_out,
    output logic [WORD_W-1:0]             data_out,
    output logic                          valid,
    output logic                          ack,
    output logic [$clog2(WAYS)-1:0]       way_out
);

    localparam int unsigned WSEL_W = $clog2(LINE_WORDS);
    localparam int unsigned WAY_W  = $clog2(WAYS);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_ACK  = 1'b1;

    logic [0:0]        state;

    logic              req_cmp;
    logic              req_write;
    logic [WSEL_W-1:0] req_word;
    logic [TAG_W-1:0]  req_tag;
    logic [WORD_W-1:0] req_data;
    logic              req_valid;

    logic [TAG_W-1:0]  tag_mem  [WAYS];
    logic [WORD_W-1:0] data_mem [WAYS][LINE_WORDS];
    logic [WAYS-1:0]   valid_r;
    logic [WAYS-1:0]   dirty_r;

    logic              match_found;
    logic [WAY_W-1:0]  match_way;
    logic              free_found;
    logic [WAY_W-1:0]  free_way;
    logic [WAY_W-1:0]  policy_way;
    logic [WAY_W-1:0]  victim_way;
    logic [WAY_W-1:0]  sel_way;

    logic              in_ack;
    logic              miss_cmp;
    logic              fill;
    logic              line_we;
    logic              use_en;

    logic              nxt_hit;
    logic              nxt_dirty;
    logic              nxt_valid;
    logic [TAG_W-1:0]  nxt_tag;
    logic [WORD_W-1:0] nxt_data;

    always_comb begin
        match_found = 1'b0;
        match_way   = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!match_found && valid_r[i] && (tag_mem[i] == req_tag)) begin
                match_found = 1'b1;
                match_way   = WAY_W'(i);
            end
        end
    end

    always_comb begin
        free_found = 1'b0;
        free_way   = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (!free_found && !valid_r[i]) begin
                free_found = 1'b1;
                free_way   = WAY_W'(i);
            end
        end
    end

    // Invalid ways are always preferred; the policy only decides among a full set.
    assign victim_way = free_found ? free_way : policy_way;
    assign sel_way    = (req_cmp && match_found) ? match_way : victim_way;

    assign in_ack   = (state == S_ACK);
    assign miss_cmp = req_cmp && !match_found;
    assign fill     = in_ack && !req_cmp && req_write;
    assign line_we  = in_ack && req_write && (!req_cmp || match_found);
    assign use_en   = in_ack && ((req_cmp && match_found) || (!req_cmp && req_write));

    always_comb begin
        nxt_hit   = req_cmp && match_found;
        nxt_tag   = fill ? req_tag : tag_mem[sel_way];
        nxt_valid = 1'b0;
        nxt_dirty = 1'b0;
        nxt_data  = '0;
        if (!miss_cmp) begin
            nxt_valid = fill ? req_valid : valid_r[sel_way];
            nxt_dirty = fill ? 1'b0 : (line_we ? 1'b1 : dirty_r[sel_way]);
            nxt_data  = line_we ? req_data : data_mem[sel_way][req_word];
        end
    end

    // Storage and request capture carry no reset; reset only blocks the update.
    always_ff @(posedge clk) begin
        if (state == S_IDLE && enable) begin
            req_cmp   <= cmp;
            req_write <= write;
            req_word  <= word;
            req_tag   <= tag;
            req_data  <= data_in;
            req_valid <= valid_in;
        end
        if (rst_n && line_we) begin
            data_mem[sel_way][req_word] <= req_data;
            if (fill) begin
                tag_mem[sel_way] <= req_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            valid_r  <= '0;
            dirty_r  <= '0;
            ack      <= 1'b0;
            hit      <= 1'b0;
            dirty    <= 1'b0;
            valid    <= 1'b0;
            tag_out  <= '0;
            data_out <= '0;
            way_out  <= '0;
        end else begin
            ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_ACK;
                    end
                end
                S_ACK: begin
                    state    <= S_IDLE;
                    ack      <= 1'b1;
                    hit      <= nxt_hit;
                    dirty    <= nxt_dirty;
                    valid    <= nxt_valid;
                    tag_out  <= nxt_tag;
                    data_out <= nxt_data;
                    way_out  <= sel_way;
                    if (fill) begin
                        valid_r[sel_way] <= req_valid;
                        dirty_r[sel_way] <= 1'b0;
                    end else if (line_we) begin
                        dirty_r[sel_way] <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CACHE_SET_LRU_EN
    logic [WAY_W-1:0] age [WAYS];

    // Age 0 is most recent; the way aged WAYS-1 is the replacement candidate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < WAYS; i++) begin
                age[i] <= WAY_W'(i);
            end
        end else if (use_en) begin
            for (int unsigned i = 0; i < WAYS; i++) begin
                if (WAY_W'(i) == sel_way) begin
                    age[i] <= '0;
                end else if (age[i] < age[sel_way]) begin
                    age[i] <= age[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        policy_way = '0;
        for (int unsigned i = 0; i < WAYS; i++) begin
            if (age[i] == WAY_W'(WAYS - 1)) begin
                policy_way = WAY_W'(i);
            end
        end
    end
`else
    logic [WAY_W-1:0] rr_ptr;

    // WAYS is a power of two, so the pointer wraps naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (fill) begin
            rr_ptr <= rr_ptr + 1'b1;
        end
    end

    assign policy_way = rr_ptr;
`endif

endmodule

// File: tb/tb_cache_set_nway.sv
// Self-checking bench for cache_set_nway: directed scenarios plus random accesses
// checked against a recency-list / pointer reference model of the set.
module tb_cache_set_nway;

    localparam int unsigned WAYS       = 2;
    localparam int unsigned TAG_W      = 5;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned LINE_WORDS = 4;
    localparam int unsigned WSEL_W     = $clog2(LINE_WORDS);
    localparam int unsigned WAY_W      = $clog2(WAYS);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              enable = 1'b0;
    logic              cmp = 1'b0;
    logic              write = 1'b0;
    logic [WSEL_W-1:0] word = '0;
    logic [TAG_W-1:0]  tag = '0;
    logic [WORD_W-1:0] data_in = '0;
    logic              valid_in = 1'b0;
    logic              hit;
    logic              dirty;
    logic [TAG_W-1:0]  tag_out;
    logic [WORD_W-1:0] data_out;
    logic              valid;
    logic              ack;
    logic [WAY_W-1:0]  way_out;

    cache_set_nway #(
        .WAYS(WAYS),
        .TAG_W(TAG_W),
        .WORD_W(WORD_W),
        .LINE_WORDS(LINE_WORDS)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .cmp(cmp), .write(write),
        .word(word), .tag(tag), .data_in(data_in), .valid_in(valid_in),
        .hit(hit), .dirty(dirty), .tag_out(tag_out), .data_out(data_out),
        .valid(valid), .ack(ack), .way_out(way_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int lat;

    // Reference model: per-way contents plus a recency list (front = most recent).
    bit                m_valid     [WAYS];
    bit                m_dirty     [WAYS];
    logic [TAG_W-1:0]  m_tag       [WAYS];
    bit                m_tag_known [WAYS];
    logic [WORD_W-1:0] m_data      [WAYS][LINE_WORDS];
    bit                m_known     [WAYS][LINE_WORDS];
    int                recency[$];
    int                rr;

    bit                e_hit, e_dirty, e_valid, e_tag_known, e_data_known;
    logic [TAG_W-1:0]  e_tag;
    logic [WORD_W-1:0] e_data;
    int                e_way;

    function automatic void model_reset();
        for (int w = 0; w < WAYS; w++) begin
            m_valid[w] = 1'b0;
            m_dirty[w] = 1'b0;
        end
        recency.delete();
        for (int w = 0; w < WAYS; w++) recency.push_back(w);
        rr = 0;
    endfunction

    function automatic void model_touch(input int w);
        for (int i = 0; i < recency.size(); i++) begin
            if (recency[i] == w) begin
                recency.delete(i);
                break;
            end
        end
        recency.push_front(w);
    endfunction

    function automatic void model_access(input bit c, input bit wr, input int wd,
                                         input logic [TAG_W-1:0] t,
                                         input logic [WORD_W-1:0] d, input bit v);
        int hw;
        int vic;
        int s;
        hw  = -1;
        vic = -1;
        for (int w = 0; w < WAYS; w++) begin
            if (hw < 0 && m_valid[w] && m_tag[w] == t) hw = w;
            if (vic < 0 && !m_valid[w]) vic = w;
        end
        if (vic < 0) begin
`ifdef CACHE_SET_LRU_EN
            vic = recency[recency.size() - 1];
`else
            vic = rr;
`endif
        end
        e_hit = 1'b0;
        if (c && hw < 0) begin
            e_way = vic; e_valid = 1'b0; e_dirty = 1'b0; e_data = '0;
            e_data_known = 1'b1; e_tag_known = 1'b0; e_tag = '0;
            return;
        end
        s = c ? hw : vic;
        if (c) begin
            e_hit = 1'b1;
            if (wr) begin
                m_data[s][wd] = d; m_known[s][wd] = 1'b1; m_dirty[s] = 1'b1;
            end
            model_touch(s);
        end else if (wr) begin
            m_data[s][wd] = d; m_known[s][wd] = 1'b1;
            m_tag[s] = t; m_tag_known[s] = 1'b1;
            m_valid[s] = v; m_dirty[s] = 1'b0;
            model_touch(s);
            rr = (rr + 1) % WAYS;
        end
        e_way = s; e_valid = m_valid[s]; e_dirty = m_dirty[s];
        e_tag = m_tag[s]; e_tag_known = m_tag_known[s];
        e_data = m_data[s][wd]; e_data_known = m_known[s][wd];
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        enable = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // Drives one access and waits (bounded) for ack; lat = negedges after enable drop.
    task automatic do_access(input bit c, input bit wr, input int wd,
                             input logic [TAG_W-1:0] t, input logic [WORD_W-1:0] d, input bit v);
        @(negedge clk);
        enable = 1'b1; cmp = c; write = wr; word = WSEL_W'(wd);
        tag = t; data_in = d; valid_in = v;
        @(negedge clk);
        enable = 1'b0;
        lat = -1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            if (ack) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", ack); end
        n_checks++;
        if ({hit, dirty, valid} !== 3'b000) begin
            n_fail++; $display("FAIL reset_flags: got %b expected 000", {hit, dirty, valid});
        end
        n_checks++;
        if (tag_out !== '0 || data_out !== '0 || way_out !== '0) begin
            n_fail++; $display("FAIL reset_fields: got tag %h data %h way %0d expected zeros", tag_out, data_out, way_out);
        end
        do_access(1'b1, 1'b0, 0, 5'b11101, 16'h0, 1'b0);
        model_access(1'b1, 1'b0, 0, 5'b11101, 16'h0, 1'b0);
        n_checks++;
        if (lat !== 1) begin n_fail++; $display("FAIL first_latency: got %0d expected 1", lat); end
        n_checks++;
        if (hit !== 1'b0 || valid !== 1'b0) begin
            n_fail++; $display("FAIL first_miss: got hit %b valid %b expected 0 0", hit, valid);
        end
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL ack_pulse_width: got %b expected 0", ack); end
    endtask

    task automatic test_fill_hit();
        do_access(1'b0, 1'b1, 3, 5'b11101, 16'h0F0F, 1'b1);
        model_access(1'b0, 1'b1, 3, 5'b11101, 16'h0F0F, 1'b1);
        n_checks++;
        if (way_out !== '0 || hit !== 1'b0 || valid !== 1'b1) begin
            n_fail++; $display("FAIL fill_way0: got way %0d hit %b valid %b expected 0 0 1", way_out, hit, valid);
        end
        do_access(1'b1, 1'b0, 3, 5'b11101, 16'h0, 1'b0);
        model_access(1'b1, 1'b0, 3, 5'b11101, 16'h0, 1'b0);
        n_checks++;
        if (hit !== 1'b1 || data_out !== 16'h0F0F || dirty !== 1'b0) begin
            n_fail++; $display("FAIL fill_readback: got hit %b data %h dirty %b expected 1 0f0f 0", hit, data_out, dirty);
        end
    endtask

    task automatic test_write_hit_miss();
        do_access(1'b1, 1'b1, 3, 5'b11101, 16'hA5A5, 1'b0);
        model_access(1'b1, 1'b1, 3, 5'b11101, 16'hA5A5, 1'b0);
        n_checks++;
        if (hit !== 1'b1 || dirty !== 1'b1 || data_out !== 16'hA5A5) begin
            n_fail++; $display("FAIL write_hit: got hit %b dirty %b data %h expected 1 1 a5a5", hit, dirty, data_out);
        end
        do_access(1'b1, 1'b1, 3, 5'b00001, 16'h1234, 1'b0);
        model_access(1'b1, 1'b1, 3, 5'b00001, 16'h1234, 1'b0);
        n_checks++;
        if (hit !== 1'b0) begin n_fail++; $display("FAIL write_miss: got hit %b expected 0", hit); end
        do_access(1'b1, 1'b0, 3, 5'b11101, 16'h0, 1'b0);
        model_access(1'b1, 1'b0, 3, 5'b11101, 16'h0, 1'b0);
        n_checks++;
        if (hit !== 1'b1 || data_out !== 16'hA5A5 || dirty !== 1'b1) begin
            n_fail++; $display("FAIL write_miss_nochange: got hit %b data %h dirty %b expected 1 a5a5 1", hit, data_out, dirty);
        end
    endtask

    task automatic test_victim();
        int exp_way;
`ifdef CACHE_SET_LRU_EN
        exp_way = 1;
`else
        exp_way = 0;
`endif
        apply_reset();
        for (int k = 1; k <= WAYS; k++) begin
            do_access(1'b0, 1'b1, 0, TAG_W'(k), WORD_W'(k), 1'b1);
            model_access(1'b0, 1'b1, 0, TAG_W'(k), WORD_W'(k), 1'b1);
            n_checks++;
            if (way_out !== WAY_W'(k - 1)) begin
                n_fail++; $display("FAIL fill_order_%0d: got way %0d expected %0d", k, way_out, k - 1);
            end
        end
        do_access(1'b1, 1'b0, 0, TAG_W'(1), 16'h0, 1'b0);
        model_access(1'b1, 1'b0, 0, TAG_W'(1), 16'h0, 1'b0);
        do_access(1'b0, 1'b0, 0, 5'b0, 16'h0, 1'b0);
        model_access(1'b0, 1'b0, 0, 5'b0, 16'h0, 1'b0);
        n_checks++;
        if (way_out !== WAY_W'(exp_way) || tag_out !== TAG_W'(exp_way + 1) || dirty !== 1'b0) begin
            n_fail++; $display("FAIL victim_select: got way %0d tag %0d dirty %b expected %0d %0d 0",
                               way_out, tag_out, dirty, exp_way, exp_way + 1);
        end
        do_access(1'b0, 1'b1, 2, 5'd9, 16'hCAFE, 1'b1);
        model_access(1'b0, 1'b1, 2, 5'd9, 16'hCAFE, 1'b1);
        n_checks++;
        if (way_out !== WAY_W'(exp_way) || tag_out !== 5'd9 || data_out !== 16'hCAFE) begin
            n_fail++; $display("FAIL victim_stable: got way %0d tag %0d data %h expected %0d 9 cafe",
                               way_out, tag_out, data_out, exp_way);
        end
    endtask

    task automatic test_back_to_back();
        int acks;
        acks = 0;
        @(negedge clk);
        enable = 1'b1; cmp = 1'b0; write = 1'b1; word = WSEL_W'(1);
        tag = 5'd7; data_in = 16'hBEEF; valid_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack) begin
                acks++;
                model_access(1'b0, 1'b1, 1, 5'd7, 16'hBEEF, 1'b1);
                n_checks++;
                if (way_out !== WAY_W'(e_way)) begin
                    n_fail++; $display("FAIL b2b_way_%0d: got %0d expected %0d", acks, way_out, e_way);
                end
            end
        end
        enable = 1'b0;
        n_checks++;
        if (acks != 3) begin n_fail++; $display("FAIL b2b_ack_count: got %0d expected 3", acks); end
        @(negedge clk);
        n_checks++;
        if (ack !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_ack: got %b expected 0", ack); end
    endtask

    task automatic test_reset_abort();
        int acks;
        acks = 0;
        @(negedge clk);
        enable = 1'b1; cmp = 1'b0; write = 1'b1; word = '0;
        tag = 5'd21; data_in = 16'h5555; valid_in = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (ack) acks++;
        end
        rst_n = 1'b1;
        model_reset();
        n_checks++;
        if (acks != 0) begin n_fail++; $display("FAIL abort_no_ack: got %0d acks expected 0", acks); end
        do_access(1'b1, 1'b0, 0, 5'd21, 16'h0, 1'b0);
        model_access(1'b1, 1'b0, 0, 5'd21, 16'h0, 1'b0);
        n_checks++;
        if (hit !== 1'b0 || valid !== 1'b0 || way_out !== '0) begin
            n_fail++; $display("FAIL abort_miss: got hit %b valid %b way %0d expected 0 0 0", hit, valid, way_out);
        end
    endtask

    task automatic test_random();
        bit c, wr, v;
        int wd;
        logic [TAG_W-1:0]  t;
        logic [WORD_W-1:0] d;
        for (int n = 0; n < 200; n++) begin
            c  = 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            v  = ($urandom_range(0, 3) != 0);
            wd = int'($urandom_range(0, LINE_WORDS - 1));
            t  = TAG_W'($urandom_range(1, WAYS + 2));
            d  = WORD_W'($urandom);
            do_access(c, wr, wd, t, d, v);
            model_access(c, wr, wd, t, d, v);
            n_checks++;
            if (lat !== 1) begin n_fail++; $display("FAIL rnd_latency[%0d]: got %0d expected 1", n, lat); end
            n_checks++;
            if (hit !== e_hit || valid !== e_valid || dirty !== e_dirty || way_out !== WAY_W'(e_way)) begin
                n_fail++; $display("FAIL rnd_status[%0d]: got hit %b valid %b dirty %b way %0d expected %b %b %b %0d",
                                   n, hit, valid, dirty, way_out, e_hit, e_valid, e_dirty, e_way);
            end
            if (e_data_known) begin
                n_checks++;
                if (data_out !== e_data) begin
                    n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", n, data_out, e_data);
                end
            end
            if (e_tag_known) begin
                n_checks++;
                if (tag_out !== e_tag) begin
                    n_fail++; $display("FAIL rnd_tag[%0d]: got %h expected %h", n, tag_out, e_tag);
                end
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int w = 0; w < WAYS; w++) begin
            m_tag_known[w] = 1'b0;
            for (int i = 0; i < LINE_WORDS; i++) m_known[w][i] = 1'b0;
        end
        model_reset();
        test_reset();
        test_fill_hit();
        test_write_hit_miss();
        test_victim();
        test_back_to_back();
        test_reset_abort();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
